// File: rtl/cafe_pago.sv
// cafe_pago -- payment stage feeding the coffee-dispense FSM.
//
// Accepts coded coins, accumulates credit, and issues a single-cycle start
// pulse P once credit covers PRICE and the dispenser is idle (busy=0).
// Surplus credit is paid back as one ret pulse per unit. Cancel refunds
// the whole credit.
//
// Parameters:
//   PRICE       cost of one drink in credit units (1..MAX_CREDIT)
//   MAX_CREDIT  credit ceiling (<=15, fits the 4-bit credit register)
//   TIMEOUT     inactivity cycles before auto-refund (8-bit counter);
//               only used when CAFE_PAGO_TIMEOUT_EN is defined
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   coin_valid   coin present this cycle
//   coin_code    coin value: 00->1, 01->2, 10->5, 11->invalid
//   cancel       refund request (level)
//   busy         dispense FSM not idle; vending is deferred
//   P            start pulse to dispense FSM, one cycle per vend
//   ret          change pulse, one cycle per returned unit
//   coin_reject  coin sampled at the previous edge was refused
//   credit       current credit
//
// Optional feature macro: CAFE_PAGO_TIMEOUT_EN (inactivity auto-refund).

module cafe_pago #(
  parameter int PRICE      = 6,
  parameter int MAX_CREDIT = 15,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_code,
  input  logic       cancel,
  input  logic       busy,
  output logic       P,
  output logic       ret,
  output logic       coin_reject,
  output logic [3:0] credit
);

  if (PRICE < 1 || PRICE > MAX_CREDIT) begin : g_bad_price
    $error("cafe_pago: PRICE must be in 1..MAX_CREDIT");
  end
  if (MAX_CREDIT > 15) begin : g_bad_max
    $error("cafe_pago: MAX_CREDIT must fit in 4 bits");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cafe_pago: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_REFUND
  } state_t;

  state_t     state_q, state_n;
  logic [3:0] credit_q, credit_n;
  logic       reject_n;
  logic [3:0] coin_val;
  logic [4:0] sum5;
  logic       coin_fits;
  logic       tmo_hit;

  // Coin decode and overflow test; the 5-bit sum keeps the compare exact.
  always_comb begin
    coin_val = 4'd0;
    case (coin_code)
      2'b00:   coin_val = 4'd1;
      2'b01:   coin_val = 4'd2;
      2'b10:   coin_val = 4'd5;
      default: coin_val = 4'd0;
    endcase
    sum5      = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits = (coin_code != 2'b11) && (sum5 <= 5'(MAX_CREDIT));
  end

`ifdef CAFE_PAGO_TIMEOUT_EN
  logic [7:0] tmo_q;

  // The edge that would take the counter to TIMEOUT is the refund edge.
  assign tmo_hit = (state_q == ST_CREDIT) && (tmo_q == 8'(TIMEOUT - 1));

  // Staying in CREDIT with unchanged credit means no coin was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == ST_CREDIT && state_n == ST_CREDIT &&
                 credit_n == credit_q) begin
      tmo_q <= tmo_q + 8'd1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state_q;
    credit_n = credit_q;
    reject_n = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          if (coin_fits) begin
            state_n  = ST_CREDIT;
            credit_n = sum5[3:0];
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      ST_CREDIT: begin
        if (cancel || tmo_hit) begin
          state_n  = ST_REFUND;
          reject_n = coin_valid;
        end else if (credit_q >= 4'(PRICE) && !busy) begin
          state_n  = ST_VEND;
          credit_n = credit_q - 4'(PRICE);
          reject_n = coin_valid;
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_n = sum5[3:0];
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      ST_VEND: begin
        reject_n = coin_valid;
        state_n  = (credit_q != 4'd0) ? ST_REFUND : ST_IDLE;
      end
      ST_REFUND: begin
        reject_n = coin_valid;
        if (credit_q <= 4'd1) begin
          credit_n = 4'd0;
          state_n  = ST_IDLE;
        end else begin
          credit_n = credit_q - 4'd1;
        end
      end
      default: begin
        state_n  = ST_IDLE;
        credit_n = 4'd0;
      end
    endcase
  end

  // P and ret are registered from the next state so each is high exactly
  // while the FSM sits in VEND / REFUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      P           <= 1'b0;
      ret         <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state_q     <= state_n;
      credit_q    <= credit_n;
      P           <= (state_n == ST_VEND);
      ret         <= (state_n == ST_REFUND);
      coin_reject <= reject_n;
    end
  end

  assign credit = credit_q;

endmodule

// File: tb/tb_cafe_pago.sv
// Self-checking bench for cafe_pago. Each driven cycle pushes the expected
// {P, ret, coin_reject, credit} for the following cycle onto a queue; the
// entry is popped and compared once the DUT has updated after the edge.

module tb_cafe_pago;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       cancel = 1'b0;
  logic       busy = 1'b0;
  logic       P, ret, coin_reject;
  logic [3:0] credit;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [6:0]  exp_q[$];

  cafe_pago #(
    .PRICE      (6),
    .MAX_CREDIT (15),
    .TIMEOUT    (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_valid  (coin_valid),
    .coin_code   (coin_code),
    .cancel      (cancel),
    .busy        (busy),
    .P           (P),
    .ret         (ret),
    .coin_reject (coin_reject),
    .credit      (credit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] got,
                          input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got P/ret/rej/credit=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
               tag, got[6], got[5], got[4], got[3:0],
               exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  function automatic logic [6:0] obs();
    return {P, ret, coin_reject, credit};
  endfunction

  // Drive one cycle, push expectation, compare after the edge.
  task automatic step(input string tag, input logic cv, input logic [1:0] cc,
                      input logic cn, input logic bz, input logic ep,
                      input logic er, input logic ej, input logic [3:0] ec);
    logic [6:0] e;
    coin_valid = cv;
    coin_code  = cc;
    cancel     = cn;
    busy       = bz;
    exp_q.push_back({ep, er, ej, ec});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, obs(), e);
  endtask

  task automatic idle(input string tag, input logic bz, input logic ep,
                      input logic er, input logic [3:0] ec);
    step(tag, 1'b0, 2'b00, 1'b0, bz, ep, er, 1'b0, ec);
  endtask

  initial begin
    logic [6:0] e;

    // Reset state
    #12;
    exp_q.push_back(7'd0);
    e = exp_q.pop_front();
    check_eq("reset", obs(), e);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 5 + 1 = 6: exact price, no change
    step("t1_coin5", 1, 2'b10, 0, 0, 0, 0, 0, 4'd5);
    step("t1_coin1", 1, 2'b00, 0, 0, 0, 0, 0, 4'd6);
    idle("t1_vend", 0, 1, 0, 4'd0);
    idle("t1_idle0", 0, 0, 0, 4'd0);
    idle("t1_idle1", 0, 0, 0, 4'd0);

    // 5 + 2 = 7: vend then one ret
    step("t2_coin5", 1, 2'b10, 0, 0, 0, 0, 0, 4'd5);
    step("t2_coin2", 1, 2'b01, 0, 0, 0, 0, 0, 4'd7);
    idle("t2_vend", 0, 1, 0, 4'd1);
    idle("t2_ret1", 0, 0, 1, 4'd1);
    idle("t2_idle", 0, 0, 0, 4'd0);

    // busy held: fill to 15, overflow reject, then vend and 9 rets
    step("t3_coin5a", 1, 2'b10, 0, 1, 0, 0, 0, 4'd5);
    step("t3_coin5b", 1, 2'b10, 0, 1, 0, 0, 0, 4'd10);
    step("t3_coin5c", 1, 2'b10, 0, 1, 0, 0, 0, 4'd15);
    step("t3_ovf", 1, 2'b00, 0, 1, 0, 0, 1, 4'd15);
    idle("t3_hold", 1, 0, 0, 4'd15);
    idle("t3_vend", 0, 1, 0, 4'd9);
    for (int i = 9; i >= 1; i--) begin
      idle($sformatf("t3_ret%0d", i), 0, 0, 1, 4'(i));
    end
    idle("t3_idle", 0, 0, 0, 4'd0);

    // credit 4, cancel with simultaneous coin
    step("t4_coin2a", 1, 2'b01, 0, 0, 0, 0, 0, 4'd2);
    step("t4_coin2b", 1, 2'b01, 0, 0, 0, 0, 0, 4'd4);
    step("t4_cancel", 1, 2'b01, 1, 0, 0, 1, 1, 4'd4);
    step("t4_ret3_coin", 1, 2'b00, 0, 0, 0, 1, 1, 4'd3);
    idle("t4_ret2", 0, 0, 1, 4'd2);
    idle("t4_ret1", 0, 0, 1, 4'd1);
    idle("t4_idle", 0, 0, 0, 4'd0);
    step("t4_bad_code", 1, 2'b11, 0, 0, 0, 0, 1, 4'd0);
    step("t4_idle_cancel", 0, 2'b00, 1, 0, 0, 0, 0, 4'd0);

    // async reset during refund with 3 units left
    step("t5_coin5", 1, 2'b10, 0, 0, 0, 0, 0, 4'd5);
    step("t5_cancel", 0, 2'b00, 1, 0, 0, 1, 0, 4'd5);
    idle("t5_ret4", 0, 0, 1, 4'd4);
    idle("t5_ret3", 0, 0, 1, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(7'd0);
    e = exp_q.pop_front();
    check_eq("t5_async_rst", obs(), e);
    @(negedge clk);
    rst_n = 1'b1;
    idle("t5_after_rst", 0, 0, 0, 4'd0);
    step("t5_coin_after", 1, 2'b00, 0, 0, 0, 0, 0, 4'd1);
    step("t5_cancel1", 0, 2'b00, 1, 0, 0, 1, 0, 4'd1);
    idle("t5_idle", 0, 0, 0, 4'd0);

    // inactivity
    step("t6_coin2", 1, 2'b01, 0, 0, 0, 0, 0, 4'd2);
`ifdef CAFE_PAGO_TIMEOUT_EN
    for (int i = 1; i <= 9; i++) begin
      idle($sformatf("t6_wait%0d", i), 0, 0, 0, 4'd2);
    end
    idle("t6_tmo_ret2", 0, 0, 1, 4'd2);
    idle("t6_tmo_ret1", 0, 0, 1, 4'd1);
    idle("t6_idle", 0, 0, 0, 4'd0);
`else
    for (int i = 1; i <= 100; i++) begin
      idle($sformatf("t6_hold%0d", i), 0, 0, 0, 4'd2);
    end
    step("t6_cancel", 0, 2'b00, 1, 0, 0, 1, 0, 4'd2);
    idle("t6_ret1", 0, 0, 1, 4'd1);
    idle("t6_idle", 0, 0, 0, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
